// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line idle level, parity selects
// and the parity helper reused by the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

    localparam logic UART_PAR_EVEN = 1'b0;
    localparam logic UART_PAR_ODD  = 1'b1;

    // Parity over the already-masked payload; odd=1 inverts the even result.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clocks-per-bit divider: counts 0..CLKS_PER_BIT-1 while run is high and flags
// the last cycle of each serial bit (bit_tick) and the cycle before it (pre_tick).
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic ck,
    input  logic clr,
    input  logic run,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    // pre_tick lets the owner register outputs that must line up with bit_tick.
    assign pre_tick = run && (cnt == PRE);

    always_ff @(posedge ck) begin
        if (!clr) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else if (!run) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else begin
            bit_tick <= pre_tick;
            cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ser.sv
// Asynchronous serial transmitter: start bit, LSB-first payload, optional parity,
// 1 or 2 stop bits, with back-to-back frames accepted in the tx_done cycle.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       ck,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t state;
    logic [7:0]     shreg;
    logic [2:0]     bitcnt;
    logic           stopcnt;
    logic           par;
    logic           bit_tick;
    logic           pre_tick;
    logic           run;
    logic           load;
    logic [7:0]     load_data;
    logic           load_par;
    logic           last_stop;

    assign run       = (state != IDLE);
    assign load      = tx_valid && tx_ready;
    assign load_data = tx_data & DATA_MASK;
    assign load_par  = uart_parity(load_data, 1'(PARITY_ODD));
    assign last_stop = (stopcnt == LAST_STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .ck      (ck),
        .clr     (clr),
        .run     (run),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    // The end-of-frame outputs are set one cycle early so tx_ready is already high
    // during the final stop cycle, letting the next frame start with no idle gap.
    always_ff @(posedge ck) begin
        if (!clr) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            stopcnt  <= 1'b0;
            par      <= 1'b0;
            txd      <= UART_IDLE_LVL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= START;
                        shreg    <= load_data;
                        par      <= load_par;
                        bitcnt   <= '0;
                        stopcnt  <= 1'b0;
                        txd      <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bitcnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd   <= par;
                            end else begin
                                state <= STOP;
                                txd   <= UART_IDLE_LVL;
                            end
                        end else begin
                            shreg  <= shreg >> 1;
                            txd    <= shreg[1];
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state <= STOP;
                        txd   <= UART_IDLE_LVL;
                    end
                end
                STOP: begin
                    if (pre_tick && last_stop) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                    if (bit_tick) begin
                        if (!last_stop) begin
                            stopcnt <= 1'b1;
                        end else if (load) begin
                            state    <= START;
                            shreg    <= load_data;
                            par      <= load_par;
                            bitcnt   <= '0;
                            stopcnt  <= 1'b0;
                            txd      <= 1'b0;
                            tx_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                            txd   <= UART_IDLE_LVL;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    txd      <= UART_IDLE_LVL;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks
// per bit share one stimulus bus; each frame is checked bit by bit.
module tb_uart_tx_ser;

    localparam int CPB = 4;

    logic       ck;
    logic       clr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] rdy_v;
    logic [3:0] txd_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int testCount;
    int failCount;

    uart_tx_ser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .ck(ck), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_ser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .ck(ck), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_ser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .ck(ck), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_ser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .ck(ck), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One handshake: tx_valid is seen at the next rising edge while all instances are ready.
    task automatic applyStimulus(input logic [7:0] data, input bit hold);
        @(negedge ck);
        tx_data  = data;
        tx_valid = 1'b1;
        @(posedge ck);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (n < 400 && !((&rdy_v) && !(|busy_v))) begin
            @(negedge ck);
            n++;
        end
        if (n >= 400) checkOutput("idle timeout", 32'd0, 32'd1);
    endtask

    // Samples instance k for nbits bit times starting in the first start-bit cycle.
    task automatic runFrame(input string name, input int k, input logic [23:0] expBits,
                            input int nbits, input int expDone, input int chgCycle,
                            input logic [7:0] chgData, input int dropCycle);
        logic txdS [256];
        logic [3:0] obs;
        int doneCount, lastDone, busyErr, readyErr, ncyc;
        doneCount = 0;
        lastDone  = -1;
        busyErr   = 0;
        readyErr  = 0;
        ncyc      = nbits * CPB;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge ck);
            txdS[c] = txd_v[k];
            if (done_v[k]) begin
                doneCount++;
                lastDone = c;
            end
            if (busy_v[k] == done_v[k]) busyErr++;
            if (rdy_v[k] != done_v[k]) readyErr++;
            if (c == chgCycle) begin
                tx_data  = chgData;
                tx_valid = 1'b1;
            end
            if (c == dropCycle) tx_valid = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            obs = {txdS[i*CPB+3], txdS[i*CPB+2], txdS[i*CPB+1], txdS[i*CPB]};
            checkOutput($sformatf("%s bit%0d", name, i), {28'd0, obs}, {28'd0, {4{expBits[i]}}});
        end
        checkOutput($sformatf("%s done count", name), doneCount, expDone);
        checkOutput($sformatf("%s done position", name), lastDone, ncyc - 1);
        checkOutput($sformatf("%s busy errors", name), busyErr, 0);
        checkOutput($sformatf("%s ready errors", name), readyErr, 0);
        @(negedge ck);
        checkOutput($sformatf("%s idle after", name),
                    {28'd0, txd_v[k], rdy_v[k], busy_v[k], done_v[k]}, 32'b1100);
    endtask

    initial begin
        int doneSeen, txdLow;
        testCount = 0;
        failCount = 0;
        clr       = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;

        repeat (3) @(negedge ck);
        checkOutput("reset txd", {31'd0, txd_v[0]}, 32'd1);
        checkOutput("reset tx_ready", {31'd0, rdy_v[0]}, 32'd1);
        checkOutput("reset busy", {31'd0, busy_v[0]}, 32'd0);
        checkOutput("reset tx_done", {31'd0, done_v[0]}, 32'd0);
        clr = 1'b1;
        repeat (2) @(negedge ck);

        applyStimulus(8'hA5, 0);
        runFrame("8n1 a5", 0, {14'd0, 1'b1, 8'hA5, 1'b0}, 10, 1, -1, 8'h00, -1);
        waitIdle();

        applyStimulus(8'h07, 0);
        runFrame("8e1 07", 1, {13'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1, -1, 8'h00, -1);
        waitIdle();

        applyStimulus(8'h07, 0);
        runFrame("8o1 07", 2, {13'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1, -1, 8'h00, -1);
        waitIdle();

        applyStimulus(8'h00, 0);
        runFrame("8n2 00", 3, {13'd0, 2'b11, 8'h00, 1'b0}, 11, 1, -1, 8'h00, -1);
        waitIdle();

        // 0xAA is presented in the tx_done cycle of the 0x55 frame.
        applyStimulus(8'h55, 1);
        runFrame("b2b", 0, {4'd0, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}, 20, 2, 39, 8'hAA, 79);
        waitIdle();

        // Data and valid disturbed mid-frame must not alter the frame.
        applyStimulus(8'h96, 0);
        runFrame("stable 96", 0, {14'd0, 1'b1, 8'h96, 1'b0}, 10, 1, 13, 8'h69, 25);
        waitIdle();

        applyStimulus(8'hFF, 0);
        repeat (10) @(negedge ck);
        clr = 1'b0;
        @(negedge ck);
        clr = 1'b1;
        checkOutput("midreset state", {28'd0, txd_v[0], rdy_v[0], busy_v[0], done_v[0]}, 32'b1100);
        doneSeen = 0;
        txdLow   = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge ck);
            if (done_v[0]) doneSeen++;
            if (!txd_v[0]) txdLow++;
        end
        checkOutput("midreset no done", doneSeen, 0);
        checkOutput("midreset line idle", txdLow, 0);
        waitIdle();

        applyStimulus(8'h3C, 0);
        runFrame("after reset 3c", 0, {14'd0, 1'b1, 8'h3C, 1'b0}, 10, 1, -1, 8'h00, -1);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
- 8N1-style asynchronous serial transmitter for the APB UART datapath.
- Accepts one parallel byte per valid/ready handshake from the TX holding path.
- Shifts the byte out on txd, LSB first, with start bit, optional parity and 1 or 2 stop bits.
- Bit timing comes from an internal clocks-per-bit divider.
- It is the transmit end of the serial link that the UART receive path samples.

Parameters:
- CLKS_PER_BIT, 16: ck cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: payload bits per frame; legal range 5..8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- ck  in  1  clock; all logic on its rising edge.
- clr  in  1  reset.
- tx_data  in  8  parallel byte; bits above DATA_BITS-1 are ignored.
- tx_valid  in  1  tx_data holds a byte to send.
- tx_ready  out  1  block can accept a byte this cycle.
- txd  out  1  serial line; idles high.
- busy  out  1  a frame is in progress.
- tx_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Interface (already decided): one clock, ck. Reset clr is synchronous and active-low: clr=0 sampled at a ck edge resets the block.
- Reset values (registered):
  - txd=1, tx_ready=1, busy=0, tx_done=0.
  - state=IDLE; bit counter, divider and shift register all 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, txd=1.
  - On tx_valid & tx_ready: latch tx_data into the shift register, compute parity from the latched bits, go to START.
  - Outputs on the next edge: tx_ready=0, busy=1, txd=0.
- Bit timing:
  - Divider counts 0..CLKS_PER_BIT-1.
  - Each serial bit holds txd for exactly CLKS_PER_BIT cycles.
  - Divider wrap advances to the next bit or state.
- START: one bit time of txd=0, then DATA.
- DATA:
  - txd = shift register bit 0 for one bit time, then shift right.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: txd = XOR of data bits, XOR PARITY_ODD, for one bit time.
- STOP: txd=1 for STOP_BITS bit times, then IDLE.
- End of frame: in the cycle txd's final stop bit ends, assert tx_done=1 for one cycle and tx_ready=1, busy=0.
- Back-to-back frames:
  - A handshake in the tx_done cycle starts the next frame.
  - txd goes low on the following edge; no idle gap is inserted.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, counted from the first txd=0 cycle.
- Input stability:
  - tx_data and tx_valid are ignored while tx_ready=0.
  - The data latched at the handshake is what is sent.
  - tx_valid may drop at any time without effect on a frame in progress.
- Reset mid-frame: on the next edge txd=1 and the block is in IDLE/ready. The abandoned frame gets no tx_done.
- Widths:
  - Divider width = $clog2(CLKS_PER_BIT).
  - Bit counter width = 3 bits, plus 1 bit for stop-bit count.
  - No arithmetic overflow is allowed for legal parameter values.

Decomposition:
- Shared package uart_pkg holds:
  - enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constant UART_IDLE_LVL=1'b1;
  - parity-select localparams, reused by the RX path.
- One sub-module, uart_baud_cnt:
  - Holds the divider, parameterised by CLKS_PER_BIT.
  - Inputs: ck, clr, run.
  - Output: bit_tick, asserted on the last cycle of each bit.
  - The RX side reuses it.

Test Plan:
- CLKS_PER_BIT=4, 8N1. Send 0xA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses exactly once after 40 cycles; busy=1 throughout the frame.
- PARITY_EN=1, PARITY_ODD=0. Send 0x07 -> parity bit 1, frame 44 cycles. Repeat with PARITY_ODD=1 -> parity bit 0.
- STOP_BITS=2. Send 0x00 -> 8 low data bits, then txd high for 8 cycles before tx_done; 44 cycles total.
- Back-to-back: tx_valid held high with 0x55, then 0xAA presented in the tx_done cycle -> second start bit on the next edge, no high gap, both bytes correct.
- Assert clr=0 for one cycle at cycle 10 of a 0xFF frame -> txd=1, tx_ready=1, busy=0 on the next edge; no tx_done. A new byte 0x3C then transmits cleanly.
- Change tx_data and toggle tx_valid mid-frame -> transmitted bits unchanged; tx_ready stays 0 until tx_done.
